// File: rtl/perceptron_train_seq.sv
// perceptron_train_seq: buffers labelled samples and drives epoch-based training of a perceptron
// Ports: clk/reset (async active-low); clear, load_valid/load_data/load_ready fill the buffer;
// start/threshold_in begin a run; p_in/p_threshold/p_exp_res drive the perceptron, p_result returns;
// busy/done/converged/epoch_count/err_count/sample_count report status.
module perceptron_train_seq #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int MAX_EPOCHS = 32,
  parameter int EP_W       = 6,
  parameter int SETTLE     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  input  logic              start,
  input  logic [7:0]        threshold_in,
  output logic [6:0]        p_in,
  output logic [7:0]        p_threshold,
  output logic              p_exp_res,
  input  logic [1:0]        p_result,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic [EP_W-1:0]   epoch_count,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W:0]   sample_count
);
  localparam int WW = $clog2(SETTLE + 1);
  typedef enum logic [2:0] {IDLE, PRESENT, WAIT, CHECK, EPOCH_END} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [DEPTH];
  logic [ADDR_W:0] sample_count_q, sample_count_d, cur_err_q, cur_err_d, err_count_q, err_count_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [EP_W-1:0] epoch_count_q, epoch_count_d;
  logic [6:0] p_in_q, p_in_d;
  logic [7:0] p_threshold_q, p_threshold_d;
  logic p_exp_res_q, p_exp_res_d, converged_q, converged_d, done_q, done_d;
  logic load_acc, err, last;
  assign load_ready   = state_q == IDLE && sample_count_q < (ADDR_W+1)'(DEPTH);
  assign load_acc     = load_valid && load_ready && !clear;
  // 2'b00 and 2'b10 never match either legal encoding, so they always grade as errors
  assign err          = p_result != (p_exp_res_q ? 2'b01 : 2'b11);
  assign last         = (ADDR_W+1)'(idx_q) + 1'b1 == sample_count_q;
  assign busy         = state_q != IDLE;
  assign done         = done_q;
  assign converged    = converged_q;
  assign epoch_count  = epoch_count_q;
  assign err_count    = err_count_q;
  assign sample_count = sample_count_q;
  assign p_in         = p_in_q;
  assign p_exp_res    = p_exp_res_q;
  assign p_threshold  = p_threshold_q;
  always_comb begin
    state_d        = state_q;
    sample_count_d = sample_count_q;
    cur_err_d      = cur_err_q;
    err_count_d    = err_count_q;
    idx_d          = idx_q;
    wait_d         = wait_q;
    epoch_count_d  = epoch_count_q;
    p_in_d         = p_in_q;
    p_exp_res_d    = p_exp_res_q;
    p_threshold_d  = p_threshold_q;
    converged_d    = converged_q;
    done_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) sample_count_d = '0;
        else if (load_acc) sample_count_d = sample_count_q + 1'b1;
        else if (start && sample_count_q != '0) begin
          p_threshold_d = threshold_in;
          epoch_count_d = '0;
          converged_d   = 1'b0;
          idx_d         = '0;
          cur_err_d     = '0;
          state_d       = PRESENT;
        end
      end
      PRESENT: begin
        p_in_d      = mem_q[idx_q][6:0];
        p_exp_res_d = mem_q[idx_q][7];
        wait_d      = WW'(SETTLE - 1);
        state_d     = WAIT;
      end
      WAIT: begin
        if (wait_q == '0) state_d = CHECK;
        else wait_d = wait_q - 1'b1;
      end
      CHECK: begin
        cur_err_d = (err && cur_err_q != (ADDR_W+1)'(DEPTH)) ? cur_err_q + 1'b1 : cur_err_q;
        if (last) state_d = EPOCH_END;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = PRESENT;
        end
      end
      EPOCH_END: begin
        err_count_d   = cur_err_q;
        epoch_count_d = epoch_count_q + 1'b1;
        if (cur_err_q == '0 || epoch_count_q + 1'b1 == EP_W'(MAX_EPOCHS)) begin
          converged_d = cur_err_q == '0;
          done_d      = 1'b1;
          p_in_d      = '0;
          p_exp_res_d = 1'b0;
          state_d     = IDLE;
        end else begin
          cur_err_d = '0;
          idx_d     = '0;
          state_d   = PRESENT;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      sample_count_q <= '0;
      cur_err_q      <= '0;
      err_count_q    <= '0;
      idx_q          <= '0;
      wait_q         <= '0;
      epoch_count_q  <= '0;
      p_in_q         <= '0;
      p_exp_res_q    <= 1'b0;
      p_threshold_q  <= '0;
      converged_q    <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sample_count_q <= sample_count_d;
      cur_err_q      <= cur_err_d;
      err_count_q    <= err_count_d;
      idx_q          <= idx_d;
      wait_q         <= wait_d;
      epoch_count_q  <= epoch_count_d;
      p_in_q         <= p_in_d;
      p_exp_res_q    <= p_exp_res_d;
      p_threshold_q  <= p_threshold_d;
      converged_q    <= converged_d;
      done_q         <= done_d;
    end
  end
  // sample storage carries no reset; contents are undefined until loaded
  always_ff @(posedge clk) begin
    if (load_acc) mem_q[sample_count_q[ADDR_W-1:0]] <= load_data;
  end
endmodule

// File: tb/tb_perceptron_train_seq.sv
// tb_perceptron_train_seq: directed bench with a timeline model of training runs
module tb_perceptron_train_seq;
  localparam int S = 2, D = 16, ME = 32;
  logic clk = 0, reset = 0, clear = 0, load_valid = 0, start = 0;
  logic [7:0] load_data = 0, threshold_in = 0;
  logic [1:0] p_result;
  logic load_ready, p_exp_res, busy, done, converged;
  logic [6:0] p_in;
  logic [7:0] p_threshold;
  logic [5:0] epoch_count;
  logic [4:0] err_count, sample_count;
  int mode = 0;
  int n_chk = 0, n_fail = 0;
  logic [7:0] m_mem [D];
  int m_cnt, m_c, m_n, m_L, m_E, m_errs, m_epochs, m_err_count;
  bit m_run, m_done, m_conv;
  logic [7:0] m_thr;
  perceptron_train_seq dut (
    .clk(clk), .reset(reset), .clear(clear), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .start(start), .threshold_in(threshold_in), .p_in(p_in),
    .p_threshold(p_threshold), .p_exp_res(p_exp_res), .p_result(p_result), .busy(busy),
    .done(done), .converged(converged), .epoch_count(epoch_count), .err_count(err_count),
    .sample_count(sample_count));
  always #5 clk = ~clk;
  // perceptron stand-in: 0 = always correct, 1 = always +1, 2 = illegal 2'b10
  always_comb p_result = mode == 0 ? (p_exp_res ? 2'b01 : 2'b11) : mode == 1 ? 2'b01 : 2'b10;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic mreset();
    m_cnt = 0; m_run = 0; m_done = 0; m_conv = 0; m_epochs = 0; m_err_count = 0;
    m_thr = 0; m_c = 0; m_L = 1; m_E = 1; m_errs = 0; m_n = 0;
  endtask
  // sample whose inputs should be on p_in at run cycle m_c: the most recently presented one
  function automatic logic [7:0] exp_entry();
    int e, o, k, ph;
    e = m_c / m_L;
    o = m_c % m_L;
    if (o == m_L - 1) return m_mem[m_n-1];
    k = o / (S + 2);
    ph = o % (S + 2);
    if (ph != 0) return m_mem[k];
    if (k > 0) return m_mem[k-1];
    return e > 0 ? m_mem[m_n-1] : 8'h00;
  endfunction
  task automatic model_step();
    if (!reset) mreset();
    else if (m_run) begin
      m_c++;
      if (m_c == m_E * m_L) begin
        m_run = 0; m_done = 1; m_epochs = m_E; m_conv = m_errs == 0; m_err_count = m_errs;
      end
    end else begin
      m_done = 0;
      if (clear) m_cnt = 0;
      else if (load_valid && m_cnt < D) begin
        m_mem[m_cnt] = load_data;
        m_cnt++;
      end else if (start && m_cnt > 0) begin
        m_run = 1; m_c = 0; m_n = m_cnt; m_thr = threshold_in; m_conv = 0; m_epochs = 0;
        m_errs = 0;
        for (int i = 0; i < m_n; i++)
          if (mode == 2 || (mode == 1 && !m_mem[i][7])) m_errs++;
        m_L = m_n * (S + 2) + 1;
        m_E = m_errs == 0 ? 1 : ME;
      end
    end
  endtask
  task automatic compare();
    logic [7:0] e;
    e = m_run ? exp_entry() : 8'h00;
    check("busy", busy, m_run);
    check("done", done, m_done);
    check("load_ready", load_ready, !m_run && m_cnt < D);
    check("sample_count", sample_count, m_cnt);
    check("p_threshold", p_threshold, m_thr);
    check("p_in", p_in, e[6:0]);
    check("p_exp_res", p_exp_res, e[7]);
    check("epoch_count", epoch_count, m_run ? m_c / m_L : m_epochs);
    check("converged", converged, m_run ? 0 : m_conv);
    check("err_count", err_count, (m_run && m_c >= m_L) ? m_errs : m_err_count);
  endtask
  task automatic tick();
    @(negedge clk) compare();
    @(posedge clk) model_step();
    #1;
  endtask
  task automatic load(input logic [7:0] d);
    load_valid = 1; load_data = d; tick(); load_valid = 0;
  endtask
  task automatic do_clear();
    clear = 1; tick(); clear = 0;
  endtask
  task automatic go(input logic [7:0] thr);
    start = 1; threshold_in = thr; tick(); start = 0;
  endtask
  task automatic run_to_done(input int budget);
    int i;
    i = 0;
    while (!m_done && i < budget) begin
      tick();
      i++;
    end
    check("done_pulse", done, 1);
  endtask
  initial begin
    mreset();
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_ready", load_ready, 1);
    reset = 1;
    tick();
    for (int i = 0; i < D; i++) load(8'(i * 7 + 3));
    check("full_ready", load_ready, 0);
    load(8'hAA);
    check("full_count", sample_count, 16);
    do_clear();
    check("clear_count", sample_count, 0);
    check("clear_ready", load_ready, 1);
    mode = 0;
    load(8'h85); load(8'h12); load(8'hFF);
    go(8'd10);
    run_to_done(200);
    check("t3_conv", converged, 1);
    check("t3_err", err_count, 0);
    check("t3_epoch", epoch_count, 1);
    check("t3_thr", p_threshold, 10);
    tick();
    do_clear();
    load(8'h81); load(8'h02); load(8'h83); load(8'h04);
    mode = 1;
    go(8'h33);
    run_to_done(2000);
    check("t4_conv", converged, 0);
    check("t4_err", err_count, 2);
    check("t4_epoch", epoch_count, 32);
    tick();
    mode = 2;
    go(8'h44);
    start = 1; load_valid = 1; load_data = 8'h55;
    repeat (3) tick();
    start = 0; load_valid = 0; clear = 1;
    tick();
    clear = 0;
    run_to_done(2000);
    check("t5_err", err_count, 4);
    check("t5_epoch", epoch_count, 32);
    check("t5_count", sample_count, 4);
    tick();
    do_clear();
    go(8'h77);
    repeat (3) tick();
    check("t5_empty_busy", busy, 0);
    check("t5_empty_done", done, 0);
    check("t5_empty_thr", p_threshold, 8'h44);
    load_valid = 1; load_data = 8'h9A; start = 1; threshold_in = 8'h11;
    tick();
    load_valid = 0; start = 0;
    check("t6_count", sample_count, 1);
    check("t6_busy", busy, 0);
    tick();
    check("t6_busy2", busy, 0);
    mode = 0;
    go(8'h22);
    tick(); tick();
    #2 reset = 0;
    #1;
    check("t1_busy", busy, 0);
    check("t1_done", done, 0);
    check("t1_count", sample_count, 0);
    check("t1_p_in", p_in, 0);
    mreset();
    tick();
    reset = 1;
    repeat (8) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
